id_redirect: RTL and testbench

ID_REDIRECT -- requirements
Module: id_redirect

---
 rtl/id_redirect.sv | 158 +++++++++++++++
 tb/tb_id_redirect.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_redirect.sv
// Decode-stage redirect unit: resolves branches and jumps from a dual-issue decode pair,
// stalls fetch while operands are outstanding and pulses redirect strobes for one cycle.
module id_redirect (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] inst_1,
  input  logic [31:0] inst_2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rt1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rt2_data,
  input  logic        rs1_ok,
  input  logic        rt1_ok,
  input  logic        rs2_ok,
  input  logic        rt2_ok,
  input  logic        delay_hard,
  output logic        branch_1,
  output logic        branch_2,
  output logic        j,
  output logic        jr,
  output logic [31:0] jr_data,
  output logic        jr_data_ok,
  output logic        delay_soft,
  output logic [31:0] last_inst_1
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] lat_inst_1, lat_inst_2;
  logic        lat_sel2;
  logic        branch_1_q, branch_2_q, j_q, jr_q;

  logic        sel2;
  logic [31:0] dec_inst;
  logic [5:0]  op;
  logic [4:0]  rtf;
  logic [5:0]  fn;
  logic        dec_ctrl, is_jt, is_jreg, need_rs, need_rt;
  logic [31:0] rs_val, rt_val;
  logic        rs_rdy, rt_rdy, ready, cond;
  logic        resolve, take, enter_wait;

  function automatic logic ctrl_op(input logic [5:0] o, input logic [4:0] r, input logic [5:0] f);
    case (o)
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000010, 6'b000011: ctrl_op = 1'b1;
      6'b000001: ctrl_op = (r == 5'b00000) || (r == 5'b00001);
      6'b000000: ctrl_op = (f == 6'b001000) || (f == 6'b001001);
      default:   ctrl_op = 1'b0;
    endcase
  endfunction

  // Slot 1 wins whenever it holds a control instruction; slot 2 is then its delay slot.
  always_comb begin
    sel2     = lat_sel2;
    dec_inst = lat_sel2 ? lat_inst_2 : lat_inst_1;
    if (state == IDLE) begin
      sel2     = !ctrl_op(inst_1[31:26], inst_1[20:16], inst_1[5:0]);
      dec_inst = sel2 ? inst_2 : inst_1;
    end
    op       = dec_inst[31:26];
    rtf      = dec_inst[20:16];
    fn       = dec_inst[5:0];
    dec_ctrl = ctrl_op(op, rtf, fn);
    is_jt    = (op == 6'b000010) || (op == 6'b000011);
    is_jreg  = (op == 6'b000000) && dec_ctrl;
    need_rt  = (op == 6'b000100) || (op == 6'b000101);
    need_rs  = dec_ctrl && !is_jt;
    rs_val   = sel2 ? rs2_data : rs1_data;
    rt_val   = sel2 ? rt2_data : rt1_data;
    rs_rdy   = sel2 ? rs2_ok : rs1_ok;
    rt_rdy   = sel2 ? rt2_ok : rt1_ok;
    ready    = (!need_rs || rs_rdy) && (!need_rt || rt_rdy);
    case (op)
      6'b000100: cond = (rs_val == rt_val);
      6'b000101: cond = (rs_val != rt_val);
      6'b000110: cond = rs_val[31] || (rs_val == 32'd0);
      6'b000111: cond = !rs_val[31] && (rs_val != 32'd0);
      6'b000001: cond = rtf[0] ? !rs_val[31] : rs_val[31];
      default:   cond = 1'b1;
    endcase
  end

  // Next state; delay_hard freezes everything and defers any resolve.
  always_comb begin
    state_nxt  = state;
    enter_wait = 1'b0;
    resolve    = 1'b0;
    delay_soft = 1'b0;
    if (!delay_hard) begin
      case (state)
        IDLE: begin
          if (in_valid && dec_ctrl) begin
            if (!ready) begin
              state_nxt  = WAIT;
              enter_wait = 1'b1;
              delay_soft = !reset;
            end else begin
              resolve   = 1'b1;
              state_nxt = cond ? FLUSH : IDLE;
            end
          end
        end
        WAIT: begin
          if (ready) begin
            resolve   = 1'b1;
            state_nxt = cond ? FLUSH : IDLE;
          end else begin
            delay_soft = !reset;
          end
        end
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    take = resolve && cond;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pulse registers only matter during FLUSH; they hold through a freeze and are masked at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_inst_1  <= 32'd0;
      lat_inst_2  <= 32'd0;
      lat_sel2    <= 1'b0;
      branch_1_q  <= 1'b0;
      branch_2_q  <= 1'b0;
      j_q         <= 1'b0;
      jr_q        <= 1'b0;
      jr_data     <= 32'd0;
      last_inst_1 <= 32'd0;
    end else if (!delay_hard) begin
      if (enter_wait) begin
        lat_inst_1 <= inst_1;
        lat_inst_2 <= inst_2;
        lat_sel2   <= sel2;
      end
      branch_1_q <= take && !sel2;
      branch_2_q <= take && sel2;
      j_q        <= take && is_jt;
      jr_q       <= take && is_jreg;
      if (take) last_inst_1 <= dec_inst;
      if (take && is_jreg) jr_data <= rs_val;
    end
  end

  assign branch_1   = branch_1_q && !delay_hard;
  assign branch_2   = branch_2_q && !delay_hard;
  assign j          = j_q && !delay_hard;
  assign jr         = jr_q && !delay_hard;
  assign jr_data_ok = jr_q && !delay_hard;

endmodule

// File: tb/tb_id_redirect.sv
// Self-checking bench for id_redirect: directed scenarios plus randomized decode pairs
// checked against a mnemonic-level reference model.
module tb_id_redirect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] inst_1 = '0, inst_2 = '0;
  logic [31:0] rs1_data = '0, rt1_data = '0, rs2_data = '0, rt2_data = '0;
  logic        rs1_ok = 1'b0, rt1_ok = 1'b0, rs2_ok = 1'b0, rt2_ok = 1'b0;
  logic        delay_hard = 1'b0;
  logic        branch_1, branch_2, j, jr, jr_data_ok, delay_soft;
  logic [31:0] jr_data, last_inst_1;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_jr_data = '0;
  logic [31:0] exp_last = '0;

  localparam logic [31:0] ADD_INST = 32'h0022_1820;
  localparam logic [31:0] J_INST   = 32'h0800_0040;

  id_redirect dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .inst_1(inst_1), .inst_2(inst_2),
    .rs1_data(rs1_data), .rt1_data(rt1_data), .rs2_data(rs2_data), .rt2_data(rt2_data),
    .rs1_ok(rs1_ok), .rt1_ok(rt1_ok), .rs2_ok(rs2_ok), .rt2_ok(rt2_ok),
    .delay_hard(delay_hard),
    .branch_1(branch_1), .branch_2(branch_2), .j(j), .jr(jr),
    .jr_data(jr_data), .jr_data_ok(jr_data_ok), .delay_soft(delay_soft),
    .last_inst_1(last_inst_1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Mnemonic codes: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr
  function automatic int refKind(input logic [31:0] inst);
    case (inst[31:26])
      6'd4: return 1;
      6'd5: return 2;
      6'd6: return 3;
      6'd7: return 4;
      6'd1: return (inst[20:16] == 5'd0) ? 5 : (inst[20:16] == 5'd1) ? 6 : 0;
      6'd2: return 7;
      6'd3: return 8;
      6'd0: return (inst[5:0] == 6'd8) ? 9 : (inst[5:0] == 6'd9) ? 10 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic refTaken(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (kind)
      1: return rs == rt;
      2: return rs != rt;
      3: return s <= 0;
      4: return s > 0;
      5: return s < 0;
      6: return s >= 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] randInst();
    logic [4:0]  a, b, d;
    logic [15:0] imm;
    logic [25:0] tgt;
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'd4, a, b, imm};
      1:  return {6'd5, a, b, imm};
      2:  return {6'd6, a, 5'd0, imm};
      3:  return {6'd7, a, 5'd0, imm};
      4:  return {6'd1, a, 5'd0, imm};
      5:  return {6'd1, a, 5'd1, imm};
      6:  return {6'd1, a, 5'd16, imm};
      7:  return {6'd2, tgt};
      8:  return {6'd3, tgt};
      9:  return {6'd0, a, 5'd0, 5'd0, 5'd0, 6'd8};
      10: return {6'd0, a, 5'd0, 5'd31, 5'd0, 6'd9};
      11: return {6'd0, a, b, d, 5'd0, 6'd32};
      12: return {6'd8, a, b, imm};
      default: return {6'd35, a, b, imm};
    endcase
  endfunction

  function automatic logic [31:0] randData();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkPulses(input string tag, input logic eb1, input logic eb2, input logic ej, input logic ejr);
    checkOutput({tag, " branch_1"}, branch_1, eb1);
    checkOutput({tag, " branch_2"}, branch_2, eb2);
    checkOutput({tag, " j"}, j, ej);
    checkOutput({tag, " jr"}, jr, ejr);
    checkOutput({tag, " jr_data_ok"}, jr_data_ok, ejr);
    checkOutput({tag, " jr_data"}, jr_data, exp_jr_data);
    checkOutput({tag, " last_inst_1"}, last_inst_1, exp_last);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decode pair from IDLE: operands held back for 'waits' cycles, then delay_hard for 'hard' cycles.
  task automatic applyStimulus(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                               input logic [31:0] r1, input logic [31:0] t1,
                               input logic [31:0] r2, input logic [31:0] t2,
                               input int waits_in, input int hard);
    int k1, k2, kind, slot, waits;
    logic [31:0] rs, rt;
    logic nrs, nrt, tk;
    k1 = refKind(i1);
    k2 = refKind(i2);
    slot = (k1 != 0) ? 1 : (k2 != 0) ? 2 : 0;
    kind = (slot == 1) ? k1 : (slot == 2) ? k2 : 0;
    rs = (slot == 2) ? r2 : r1;
    rt = (slot == 2) ? t2 : t1;
    nrs = kind inside {[1:6], 9, 10};
    nrt = kind inside {1, 2};
    waits = (nrs || nrt) ? waits_in : 0;
    tk = (slot != 0) && refTaken(kind, rs, rt);

    in_valid = 1'b1;
    inst_1 = i1; inst_2 = i2;
    rs1_data = r1; rt1_data = t1; rs2_data = r2; rt2_data = t2;
    rs1_ok = 1'($urandom); rt1_ok = 1'($urandom); rs2_ok = 1'($urandom); rt2_ok = 1'($urandom);
    if (slot == 1) begin
      if (nrs) rs1_ok = (waits == 0);
      if (nrt) rt1_ok = (waits == 0);
    end else if (slot == 2) begin
      if (nrs) rs2_ok = (waits == 0);
      if (nrt) rt2_ok = (waits == 0);
    end
    #1 checkOutput({tag, " delay_soft first"}, delay_soft, (slot != 0) && (waits > 0));

    if (slot == 0) begin
      tick();
      in_valid = 1'b0;
      checkPulses({tag, " noctrl"}, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end

    for (int w = 0; w < waits; w++) begin
      tick();
      if (w == 0) begin
        in_valid = 1'b0;
        inst_1 = randInst();
        inst_2 = randInst();
      end
      if (w < waits - 1) begin
        #1 checkOutput({tag, " delay_soft wait"}, delay_soft, 1'b1);
      end
    end

    if (slot == 1) begin
      if (nrs) rs1_ok = 1'b1;
      if (nrt) rt1_ok = 1'b1;
    end else begin
      if (nrs) rs2_ok = 1'b1;
      if (nrt) rt2_ok = 1'b1;
    end
    #1 checkOutput({tag, " delay_soft ready"}, delay_soft, 1'b0);

    if (hard > 0) begin
      delay_hard = 1'b1;
      for (int h = 0; h < hard; h++) begin
        tick();
        checkPulses({tag, " frozen"}, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      delay_hard = 1'b0;
    end

    tick();
    in_valid = 1'b0;
    if (tk) begin
      exp_last = (slot == 1) ? i1 : i2;
      if (kind inside {9, 10}) exp_jr_data = rs;
    end
    checkPulses({tag, " resolve"}, tk && (slot == 1), tk && (slot == 2),
                tk && (kind inside {7, 8}), tk && (kind inside {9, 10}));

    if (tk) begin
      in_valid = 1'b1;
      inst_1 = J_INST;
      inst_2 = ADD_INST;
      tick();
      in_valid = 1'b0;
      checkPulses({tag, " flush"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rr1, rr2, tt1, tt2;

    in_valid = 1'b1;
    inst_1 = {6'd0, 5'd3, 5'd0, 5'd0, 5'd0, 6'd8};
    #12;
    checkOutput("reset delay_soft", delay_soft, 1'b0);
    checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #4 reset = 1'b0;
    tick();

    applyStimulus("beq_s1", {6'd4, 5'd1, 5'd2, 16'h0010}, ADD_INST,
                  32'h5, 32'h5, 32'h0, 32'h0, 0, 0);
    applyStimulus("bne_s2", ADD_INST, {6'd5, 5'd4, 5'd5, 16'h0020},
                  32'h1, 32'h2, 32'h7, 32'h7, 0, 0);
    applyStimulus("jr_wait", {6'd0, 5'd9, 5'd0, 5'd0, 5'd0, 6'd8}, ADD_INST,
                  32'h8000_0100, 32'h0, 32'h0, 32'h0, 2, 0);
    applyStimulus("beq_j", {6'd4, 5'd1, 5'd1, 16'h0004}, {6'd2, 26'h100},
                  32'hABCD, 32'hABCD, 32'h0, 32'h0, 0, 0);
    applyStimulus("bgtz_neg", ADD_INST, {6'd7, 5'd6, 5'd0, 16'h0008},
                  32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
    applyStimulus("bgtz_hard", ADD_INST, {6'd7, 5'd6, 5'd0, 16'h0008},
                  32'h0, 32'h0, 32'h1, 32'h0, 0, 3);

    // Reset while waiting on an operand.
    in_valid = 1'b1;
    inst_1 = {6'd0, 5'd7, 5'd0, 5'd0, 5'd0, 6'd8};
    inst_2 = ADD_INST;
    rs1_data = 32'h1234_5678;
    rs1_ok = 1'b0;
    #1 checkOutput("rstwait delay_soft idle", delay_soft, 1'b1);
    tick();
    in_valid = 1'b0;
    #1 checkOutput("rstwait delay_soft wait", delay_soft, 1'b1);
    #2 reset = 1'b1;
    exp_jr_data = '0;
    exp_last = '0;
    #1 checkOutput("rstwait delay_soft", delay_soft, 1'b0);
    checkPulses("rstwait", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1 checkOutput("rstwait idle after", delay_soft, 1'b0);
    tick();
    checkOutput("rstwait idle next", delay_soft, 1'b0);

    // Reset in the middle of FLUSH.
    in_valid = 1'b1;
    inst_1 = J_INST;
    tick();
    in_valid = 1'b0;
    exp_last = J_INST;
    checkPulses("rstflush pre", 1'b1, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    exp_last = '0;
    #1 checkPulses("rstflush", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    tick();

    for (int n = 0; n < 60; n++) begin
      rr1 = randData(); rr2 = randData();
      tt1 = ($urandom_range(0, 2) == 0) ? rr1 : randData();
      tt2 = ($urandom_range(0, 2) == 0) ? rr2 : randData();
      applyStimulus("rand", randInst(), randInst(), rr1, tt1, rr2, tt2,
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
